// File: rtl/wb_trace_buf.sv
// Writeback-trace capture buffer: tags retired instructions with a sequence
// number and queues them in a FWFT FIFO drained over a valid/ready stream.
// Optional build macro: WB_TRACE_X0_MASK_EN (hide writes to register x0).
module wb_trace_buf #(
  parameter int DEPTH  = 16,
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int SEQ_W  = 16,
  parameter int DROP_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       capture_en,
  input  logic                       clear,
  input  logic                       wb_have_inst,
  input  logic [PC_W-1:0]            wb_pc,
  input  logic                       wb_ena,
  input  logic [REG_W-1:0]           wb_reg,
  input  logic [DATA_W-1:0]          wb_value,
  output logic                       tr_valid,
  input  logic                       tr_ready,
  output logic [SEQ_W-1:0]           tr_seq,
  output logic [PC_W-1:0]            tr_pc,
  output logic                       tr_ena,
  output logic [REG_W-1:0]           tr_reg,
  output logic [DATA_W-1:0]          tr_value,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int ENT_W = SEQ_W + PC_W + 1 + REG_W + DATA_W;

  logic [ENT_W-1:0]  mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [SEQ_W-1:0]  seq;
  logic [ENT_W-1:0]  head;
  logic              empty, full, push_req, pop, do_push, drop;
  logic              st_ena;
  logic [DATA_W-1:0] st_value;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign tr_valid = !empty;
  assign push_req = wb_have_inst && capture_en;
  assign pop      = tr_valid && tr_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    st_ena   = wb_ena;
    st_value = wb_value;
`ifdef WB_TRACE_X0_MASK_EN
    if (wb_reg == '0) begin
      st_ena   = 1'b0;
      st_value = '0;
    end
`endif
  end

  // Storage is deliberately not reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !clear)
      mem[wr_ptr[AW-1:0]] <= {seq, wb_pc, st_ena, wb_reg, st_value};
  end

  assign head = tr_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign {tr_seq, tr_pc, tr_ena, tr_reg, tr_value} = head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      seq      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      seq      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (wb_have_inst) seq <= seq + {{(SEQ_W-1){1'b0}}, 1'b1};
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      case ({do_push, pop})
        2'b10:   count <= count + {{AW{1'b0}}, 1'b1};
        2'b01:   count <= count - {{AW{1'b0}}, 1'b1};
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + {{(DROP_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_wb_trace_buf.sv
// Directed bench for wb_trace_buf (DEPTH=16): table of single-cycle vectors
// plus hand sequences for fill/overflow, full pass-through, clear and x0 handling.
module tb_wb_trace_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        capture_en = 1'b0, clear = 1'b0, wb_have_inst = 1'b0;
  logic [31:0] wb_pc = '0;
  logic        wb_ena = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic [31:0] wb_value = '0;
  logic        tr_valid, tr_ready = 1'b0;
  logic [15:0] tr_seq;
  logic [31:0] tr_pc;
  logic        tr_ena;
  logic [4:0]  tr_reg;
  logic [31:0] tr_value;
  logic [4:0]  count;
  logic        overflow;
  logic [15:0] drop_cnt;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  wb_trace_buf #(.DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .capture_en(capture_en), .clear(clear),
    .wb_have_inst(wb_have_inst), .wb_pc(wb_pc), .wb_ena(wb_ena),
    .wb_reg(wb_reg), .wb_value(wb_value), .tr_valid(tr_valid),
    .tr_ready(tr_ready), .tr_seq(tr_seq), .tr_pc(tr_pc), .tr_ena(tr_ena),
    .tr_reg(tr_reg), .tr_value(tr_value), .count(count),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  // Payload fields are derived from the PC so every entry is distinguishable.
  function automatic logic [4:0] reg_of(input logic [31:0] pc);
    return pc[6:2] | 5'd1;
  endfunction
  function automatic logic [31:0] val_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  typedef struct {
    logic        clr, cap, hv;
    logic [31:0] pc;
    logic        rdy;
    logic        ev;
    logic [15:0] es;
    logic [31:0] ep;
    logic [4:0]  ec;
    logic        eo;
    logic [15:0] ed;
  } vec_t;

  function automatic vec_t mk(input logic clr, cap, hv, input logic [31:0] pc,
                              input logic rdy, ev, input logic [15:0] es,
                              input logic [31:0] ep, input logic [4:0] ec,
                              input logic eo, input logic [15:0] ed);
    vec_t v;
    v.clr = clr; v.cap = cap; v.hv = hv; v.pc = pc; v.rdy = rdy;
    v.ev = ev; v.es = es; v.ep = ep; v.ec = ec; v.eo = eo; v.ed = ed;
    return v;
  endfunction

  task automatic check(input string nm, input logic ev, input logic [15:0] es,
                       input logic [31:0] ep, input logic ee, input logic [4:0] er,
                       input logic [31:0] evl, input logic [4:0] ec,
                       input logic eo, input logic [15:0] ed);
    nvec++;
    if ({tr_valid, tr_seq, tr_pc, tr_ena, tr_reg, tr_value, count, overflow, drop_cnt}
        !== {ev, es, ep, ee, er, evl, ec, eo, ed}) begin
      nmis++;
      $display("FAIL %s: got valid=%0b seq=%0d pc=%h ena=%0b reg=%0d val=%h cnt=%0d ovf=%0b drop=%0d; want valid=%0b seq=%0d pc=%h ena=%0b reg=%0d val=%h cnt=%0d ovf=%0b drop=%0d",
               nm, tr_valid, tr_seq, tr_pc, tr_ena, tr_reg, tr_value, count, overflow, drop_cnt,
               ev, es, ep, ee, er, evl, ec, eo, ed);
    end
  endtask

  task automatic check_std(input string nm, input logic ev, input logic [15:0] es,
                           input logic [31:0] ep, input logic [4:0] ec,
                           input logic eo, input logic [15:0] ed);
    if (ev) check(nm, 1'b1, es, ep, 1'b1, reg_of(ep), val_of(ep), ec, eo, ed);
    else    check(nm, 1'b0, 16'd0, 32'd0, 1'b0, 5'd0, 32'd0, ec, eo, ed);
  endtask

  task automatic step(input logic clr, cap, hv, input logic [31:0] pc, input logic rdy);
    clear = clr; capture_en = cap; wb_have_inst = hv; tr_ready = rdy;
    wb_pc = pc; wb_ena = 1'b1; wb_reg = reg_of(pc); wb_value = val_of(pc);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0]  = mk(0,1,1,32'h00,0, 1,16'd0,32'h00,5'd1,0,16'd0);
    tbl[1]  = mk(0,1,1,32'h04,0, 1,16'd0,32'h00,5'd2,0,16'd0);
    tbl[2]  = mk(0,1,1,32'h08,0, 1,16'd0,32'h00,5'd3,0,16'd0);
    tbl[3]  = mk(0,0,0,32'h00,1, 1,16'd1,32'h04,5'd2,0,16'd0);
    tbl[4]  = mk(0,0,0,32'h00,1, 1,16'd2,32'h08,5'd1,0,16'd0);
    tbl[5]  = mk(0,0,0,32'h00,1, 0,16'd0,32'h00,5'd0,0,16'd0);
    tbl[6]  = mk(0,1,1,32'h10,0, 1,16'd3,32'h10,5'd1,0,16'd0);
    tbl[7]  = mk(0,0,0,32'h00,0, 1,16'd3,32'h10,5'd1,0,16'd0);
    tbl[8]  = mk(0,1,1,32'h14,0, 1,16'd3,32'h10,5'd2,0,16'd0);
    tbl[9]  = mk(0,0,1,32'h18,0, 1,16'd3,32'h10,5'd2,0,16'd0);
    tbl[10] = mk(0,1,1,32'h1c,0, 1,16'd3,32'h10,5'd3,0,16'd0);
    tbl[11] = mk(0,0,0,32'h00,1, 1,16'd4,32'h14,5'd2,0,16'd0);
    tbl[12] = mk(0,0,0,32'h00,1, 1,16'd6,32'h1c,5'd1,0,16'd0);
    tbl[13] = mk(0,0,0,32'h00,1, 0,16'd0,32'h00,5'd0,0,16'd0);
    tbl[14] = mk(0,1,1,32'h20,1, 1,16'd7,32'h20,5'd1,0,16'd0);
    tbl[15] = mk(0,0,0,32'h00,1, 0,16'd0,32'h00,5'd0,0,16'd0);

    repeat (2) @(posedge clk);
    #1;
    check_std("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].clr, tbl[i].cap, tbl[i].hv, tbl[i].pc, tbl[i].rdy);
      check_std($sformatf("vec%0d", i), tbl[i].ev, tbl[i].es, tbl[i].ep,
                tbl[i].ec, tbl[i].eo, tbl[i].ed);
    end

    // Asynchronous reset mid-operation with one entry queued.
    step(0, 1, 1, 32'h40, 0);
    rst_n = 1'b0;
    #2;
    check_std("async_rst", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1, 32'(i * 4), 0);
      if (i == 15) check_std("fill16", 1, 16'd0, 32'h0, 5'd16, 0, 16'd0);
      if (i == 19) check_std("fill20", 1, 16'd0, 32'h0, 5'd16, 1, 16'd4);
    end

    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 32'h0, 1);
      if (i < 15) check_std($sformatf("drain%0d", i), 1, 16'(i + 1), 32'((i + 1) * 4),
                            5'(15 - i), 1, 16'd4);
      else        check_std("drain_end", 0, 0, 0, 5'd0, 1, 16'd4);
    end

    // Seq continues at 20 after the 20 retires above.
    for (int i = 0; i < 16; i++) step(0, 1, 1, 32'h200 + 32'(i * 4), 0);
    check_std("refill", 1, 16'd20, 32'h200, 5'd16, 1, 16'd4);

    for (int k = 0; k < 8; k++) begin
      step(0, 1, 1, 32'h300 + 32'(k * 4), 1);
      check_std($sformatf("pass%0d", k), 1, 16'(21 + k), 32'h200 + 32'((k + 1) * 4),
                5'd16, 1, 16'd4);
    end

    for (int j = 0; j < 11; j++) begin
      step(0, 0, 0, 32'h0, 1);
      if (j <= 6) check_std($sformatf("pop%0d", j), 1, 16'(29 + j),
                            32'h200 + 32'((9 + j) * 4), 5'(15 - j), 1, 16'd4);
      else        check_std($sformatf("pop%0d", j), 1, 16'(29 + j),
                            32'h300 + 32'((j - 7) * 4), 5'(15 - j), 1, 16'd4);
    end

    step(1, 1, 1, 32'h400, 1);
    check_std("clear", 0, 0, 0, 5'd0, 0, 16'd0);

    // x0 write right after clear: tagged seq 0.
    clear = 1'b0; capture_en = 1'b1; wb_have_inst = 1'b1; tr_ready = 1'b0;
    wb_pc = 32'h100; wb_ena = 1'b1; wb_reg = 5'd0; wb_value = 32'h1234;
    @(posedge clk);
    #1;
`ifdef WB_TRACE_X0_MASK_EN
    check("x0_masked", 1, 16'd0, 32'h100, 1'b0, 5'd0, 32'h0, 5'd1, 0, 16'd0);
`else
    check("x0_raw", 1, 16'd0, 32'h100, 1'b1, 5'd0, 32'h1234, 5'd1, 0, 16'd0);
`endif
    wb_have_inst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/wb_trace_buf.md
# wb_trace_buf

Parametrised writeback-trace capture buffer for the miniRV CPU family. It sits beside the CPU top and samples the `debug_wb_*` trace bus every cycle. Retired instructions are stored, each tagged with a sequence number, in a first-word-fall-through FIFO. A valid/ready stream drains the FIFO to a host or checker. Unlike the single-cycle top, where `debug_wb_have_inst` is tied to 1, this block handles pipelined cores with bubbles, back-pressure, overflow accounting and flush.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, minimum 2.
- `PC_W`, 32: width of `wb_pc` / `tr_pc`.
- `DATA_W`, 32: width of `wb_value` / `tr_value`.
- `REG_W`, 5: register-index width.
- `SEQ_W`, 16: sequence-counter width.
- `DROP_W`, 16: dropped-entry counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `capture_en` in 1: high = retired instructions are pushed.
- `clear` in 1: synchronous flush.
- `wb_have_inst` in 1: an instruction retires this cycle.
- `wb_pc` in PC_W: PC of the retiring instruction.
- `wb_ena` in 1: register-file write enable.
- `wb_reg` in REG_W: destination register.
- `wb_value` in DATA_W: value written back.
- `tr_valid` out 1: head entry available.
- `tr_ready` in 1: consumer accepts the head entry.
- `tr_seq` out SEQ_W: sequence number of the head entry.
- `tr_pc` out PC_W: head entry field.
- `tr_ena` out 1: head entry field.
- `tr_reg` out REG_W: head entry field.
- `tr_value` out DATA_W: head entry field.
- `count` out clog2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky; set when an entry has been lost.
- `drop_cnt` out DROP_W: number of lost entries; saturates.

## Operation
- Retire event: `wb_have_inst`=1 at a rising edge.
- `seq` register: increments by 1 on every retire event, whether or not the entry is captured or dropped; wraps modulo 2^SEQ_W. The stored tag is the `seq` value before the increment, so the first retire after reset is tagged 0.
- Push request: retire event and `capture_en`=1. The entry stored is {seq, wb_pc, wb_ena, wb_reg, wb_value}.
- Pop: `tr_valid` and `tr_ready` both high at a rising edge.
- Full FIFO, push without pop: the entry is dropped, `overflow` is set to 1, and `drop_cnt` increments, saturating at all-ones.
- Full FIFO, push with pop: both happen. `count` is unchanged and nothing is dropped.
- Empty FIFO, push with pop: the pop is ignored (`tr_valid`=0). The push is accepted.
- `clear`=1: read/write pointers, `count`, `overflow`, `drop_cnt` and `seq` all go to 0. `clear` overrides any push or pop in the same cycle, and that push is not counted as dropped.
- `tr_valid`=0: `tr_pc`, `tr_ena`, `tr_reg`, `tr_value` and `tr_seq` are driven to 0.
- Pointers: clog2(DEPTH) bits plus a wrap bit; full/empty are derived from pointer comparison.

## Timing
- Reset (asynchronous): all outputs 0, `seq` 0, FIFO empty. Storage contents are not reset. Asserting reset mid-operation discards all entries immediately.
- Latency: an entry pushed at edge N is on the `tr_*` outputs, with `tr_valid`=1, after edge N when the FIFO was empty (FWFT).
- `count`, `overflow` and `drop_cnt` are registered and update at the same edge as the push or pop.
- The `tr_*` payload holds stable while `tr_valid`=1 and `tr_ready`=0.
- `tr_ready` may be held high permanently.
- `capture_en` and `clear` are sampled only at clock edges.

## Configuration
- `WB_TRACE_X0_MASK_EN` defined: when a pushed entry has `wb_reg`=0, it is stored with `tr_ena`=0 and `tr_value`=0. This hides x0 writes, which the architecture discards.
- Macro undefined: entries are stored exactly as sampled.
- Counters and all other behaviour are identical in both builds.

## Test plan
- Reset, then 3 retires with PCs 0x0, 0x4, 0x8 and `tr_ready`=0: `count`=3; head shows `tr_seq`=0, `tr_pc`=0x0. Raise `tr_ready`: the next two cycles show PCs 0x4 then 0x8, then `tr_valid`=0 and all outputs 0.
- DEPTH=16, `tr_ready`=0, 20 consecutive retires: `count`=16, `overflow`=1, `drop_cnt`=4. Draining yields `tr_seq` 0..15.
- Full FIFO, `tr_ready`=1, continuous retires: `count` stays 16, `drop_cnt` is unchanged, and popped `tr_seq` values are consecutive.
- `wb_have_inst` toggling 1,0,1 with `capture_en`=0 on the middle retire-less cycle, then `capture_en`=0 on one retire: that entry is absent and the next captured entry's `tr_seq` skips by 2.
- `clear` asserted together with a push while `count`=5 and `overflow`=1: next cycle `count`=0, `overflow`=0, `drop_cnt`=0, `tr_valid`=0. The next retire is tagged seq 0.
- Retire with `wb_ena`=1, `wb_reg`=0, `wb_value`=0x1234: with `WB_TRACE_X0_MASK_EN` the head shows `tr_ena`=0, `tr_value`=0. Without it, `tr_ena`=1, `tr_value`=0x1234.
